// File: rtl/vad_pkg.sv
// Shared types and defaults for the VAD decision stage.
package vad_pkg;

    typedef enum logic [1:0] {
        SILENCE  = 2'd0,
        ONSET    = 2'd1,
        SPEECH   = 2'd2,
        HANGOVER = 2'd3
    } vad_state_t;

    localparam int VAD_SCORE_W  = 8;
    localparam int VAD_ON_CNT   = 3;
    localparam int VAD_HANG_LEN = 8;
    localparam int VAD_FRAME_W  = 16;

    function automatic int vad_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vad_score_cmp.sv
// Per-frame raw decision: speech wins when its score beats noise by more than MARGIN.
module vad_score_cmp
    import vad_pkg::*;
#(
    parameter int SCORE_W = VAD_SCORE_W,
    parameter int MARGIN  = 0
) (
    input  logic signed [SCORE_W-1:0] score_speech,
    input  logic signed [SCORE_W-1:0] score_noise,
    output logic                      raw
);

    // Two guard bits keep the difference exact for any pair of scores and any in-range margin.
    localparam int EXT_W = SCORE_W + 2;
    localparam logic signed [EXT_W-1:0] MARGIN_EXT = EXT_W'(MARGIN);

    logic signed [EXT_W-1:0] speech_ext;
    logic signed [EXT_W-1:0] noise_ext;
    logic signed [EXT_W-1:0] diff;

    assign speech_ext = {{2{score_speech[SCORE_W-1]}}, score_speech};
    assign noise_ext  = {{2{score_noise[SCORE_W-1]}}, score_noise};
    assign diff       = speech_ext - noise_ext;
    assign raw        = diff > MARGIN_EXT;

endmodule

// File: rtl/vad_decision.sv
// VAD smoothing: frame edge detect, onset confirmation and hangover FSM.
// Optional VAD_STATS_EN adds a saturating count of speech frames.
module vad_decision
    import vad_pkg::*;
#(
    parameter int SCORE_W  = VAD_SCORE_W,
    parameter int MARGIN   = 0,
    parameter int ON_CNT   = VAD_ON_CNT,
    parameter int HANG_LEN = VAD_HANG_LEN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [SCORE_W-1:0] score_speech,
    input  logic signed [SCORE_W-1:0] score_noise,
    input  logic                      mac_done,
    input  logic                      flush,
    output logic                      vad_raw,
    output logic                      vad_out,
    output logic                      vad_valid,
    output logic [1:0]                fsm_state
`ifdef VAD_STATS_EN
    ,
    output logic [VAD_FRAME_W-1:0]    speech_frames
`endif
);

    localparam int CNT_W = $clog2(vad_max(ON_CNT, HANG_LEN) + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CNT - 1);
    localparam logic [CNT_W-1:0] HANG_INIT = CNT_W'(HANG_LEN - 1);

    vad_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             done_d;
    logic             accept;
    logic             raw;
    logic             out_nxt;

    vad_score_cmp #(
        .SCORE_W (SCORE_W),
        .MARGIN  (MARGIN)
    ) u_cmp (
        .score_speech (score_speech),
        .score_noise  (score_noise),
        .raw          (raw)
    );

    // A frame is the rising edge of the done level, so a long level is one frame.
    assign accept    = mac_done && !done_d;
    assign fsm_state = state;

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            SILENCE: begin
                if (raw) begin
                    if (ON_CNT == 1) begin
                        state_nxt = SPEECH;
                    end else begin
                        state_nxt = ONSET;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            ONSET: begin
                if (!raw) begin
                    state_nxt = SILENCE;
                    cnt_nxt   = '0;
                end else if (cnt == ON_LAST) begin
                    state_nxt = SPEECH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            SPEECH: begin
                if (!raw) begin
                    if (HANG_LEN == 0) begin
                        state_nxt = SILENCE;
                    end else begin
                        state_nxt = HANGOVER;
                        cnt_nxt   = HANG_INIT;
                    end
                end
            end
            HANGOVER: begin
                if (raw) begin
                    state_nxt = SPEECH;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = SILENCE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
        endcase
        out_nxt = (state_nxt == SPEECH) || (state_nxt == HANGOVER);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_d    <= 1'b0;
            state     <= SILENCE;
            cnt       <= '0;
            vad_raw   <= 1'b0;
            vad_out   <= 1'b0;
            vad_valid <= 1'b0;
        end else begin
            done_d    <= mac_done;
            vad_valid <= 1'b0;
            if (flush) begin
                state   <= SILENCE;
                cnt     <= '0;
                vad_raw <= 1'b0;
                vad_out <= 1'b0;
            end else if (accept) begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                vad_raw   <= raw;
                vad_out   <= out_nxt;
                vad_valid <= 1'b1;
            end
        end
    end

`ifdef VAD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speech_frames <= '0;
        end else if (flush) begin
            speech_frames <= '0;
        end else if (accept && out_nxt && (speech_frames != '1)) begin
            speech_frames <= speech_frames + VAD_FRAME_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_vad_decision.sv
// Self-checking bench for vad_decision: run-length reference model plus directed frames.
module tb_vad_decision;

    localparam int ON_CNT   = 3;
    localparam int HANG_LEN = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic signed [7:0] score_speech = '0;
    logic signed [7:0] score_noise = '0;
    logic              mac_done = 1'b0;
    logic              flush = 1'b0;

    logic       vad_raw, vad_out, vad_valid;
    logic [1:0] fsm_state;
    logic       m_raw, m_out, m_valid;
    logic [1:0] m_state;
`ifdef VAD_STATS_EN
    logic [15:0] speech_frames, m_frames;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vad_decision #(.SCORE_W(8), .MARGIN(0), .ON_CNT(ON_CNT), .HANG_LEN(HANG_LEN)) dut (
        .clk (clk), .rst_n (rst_n), .score_speech (score_speech), .score_noise (score_noise),
        .mac_done (mac_done), .flush (flush), .vad_raw (vad_raw), .vad_out (vad_out),
        .vad_valid (vad_valid), .fsm_state (fsm_state)
`ifdef VAD_STATS_EN
        , .speech_frames (speech_frames)
`endif
    );

    // Second instance differs only in MARGIN, to exercise a negative bias on ties.
    vad_decision #(.SCORE_W(8), .MARGIN(-1), .ON_CNT(ON_CNT), .HANG_LEN(HANG_LEN)) dut_m (
        .clk (clk), .rst_n (rst_n), .score_speech (score_speech), .score_noise (score_noise),
        .mac_done (mac_done), .flush (flush), .vad_raw (m_raw), .vad_out (m_out),
        .vad_valid (m_valid), .fsm_state (m_state)
`ifdef VAD_STATS_EN
        , .speech_frames (m_frames)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: tracks runs of speech/noise frames rather than FSM counters.
    int   speech_run, noise_run, exp_frames;
    bit   active, prev_done;
    logic exp_raw, exp_raw_m, exp_out, exp_valid;
    logic [1:0] exp_state;

    task automatic model_reset();
        speech_run = 0; noise_run = 0; exp_frames = 0; active = 0; prev_done = 0;
        exp_raw = 0; exp_raw_m = 0; exp_out = 0; exp_valid = 0; exp_state = 2'd0;
    endtask

    task automatic model_frame();
        int d;
        d = int'(score_speech) - int'(score_noise);
        exp_raw   = d > 0;
        exp_raw_m = d > -1;
        if (exp_raw) begin
            speech_run++;
            noise_run = 0;
            if (speech_run >= ON_CNT) active = 1;
        end else begin
            noise_run++;
            speech_run = 0;
            if (active && noise_run > HANG_LEN) active = 0;
        end
        exp_out   = active;
        exp_state = active ? (exp_raw ? 2'd2 : 2'd3) : (speech_run > 0 ? 2'd1 : 2'd0);
        if (active && exp_frames < 65535) exp_frames++;
        exp_valid = 1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                exp_valid = 0;
                if (flush) begin
                    speech_run = 0; noise_run = 0; active = 0; exp_frames = 0;
                    exp_raw = 0; exp_raw_m = 0; exp_out = 0; exp_state = 2'd0;
                end else if (mac_done && !prev_done) begin
                    model_frame();
                end
                prev_done = mac_done;
            end
            @(negedge clk);
            if (!rst_n) model_reset();
            check("valid", vad_valid, exp_valid);
            check("out", vad_out, exp_out);
            check("raw", vad_raw, exp_raw);
            check("state", fsm_state, exp_state);
            check("margin_valid", m_valid, exp_valid);
            check("margin_raw", m_raw, exp_raw_m);
`ifdef VAD_STATS_EN
            check("speech_frames", speech_frames, exp_frames);
`endif
        end
    end

    // One frame: raise mac_done for one cycle and pin the registered result one edge later.
    task automatic frame(input int s, input int n, input logic e_out, input logic [1:0] e_st);
        @(posedge clk); #1;
        score_speech = 8'(s);
        score_noise  = 8'(n);
        mac_done     = 1'b1;
        @(posedge clk); #1;
        check("frame_valid", vad_valid, 1);
        check("frame_out", vad_out, e_out);
        check("frame_state", fsm_state, e_st);
        mac_done = 1'b0;
    endtask

    initial begin
        int extra;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_out", vad_out, 0);
        check("idle_valid", vad_valid, 0);
        check("idle_state", fsm_state, 0);

        for (int i = 0; i < 3; i++) frame(5, 1, (i == 2), (i == 2) ? 2'd2 : 2'd1);
        for (int i = 0; i < 3; i++) frame(1, 5, (i != 2), (i == 2) ? 2'd0 : 2'd3);
        frame(5, 1, 0, 2'd1);
        frame(1, 5, 0, 2'd0);
        frame(5, 1, 0, 2'd1);

        frame(3, 3, 0, 2'd0);
        check("tie_raw", vad_raw, 0);
        check("tie_margin_raw", m_raw, 1);
        frame(127, -128, 0, 2'd1);
        check("max_raw", vad_raw, 1);
        frame(-128, 127, 0, 2'd0);
        check("min_raw", vad_raw, 0);
        check("min_margin_raw", m_raw, 0);

        // Level held for 20 cycles must yield one frame, visible one edge after the rise.
        @(posedge clk); #1;
        score_speech = 8'sd5; score_noise = 8'sd1; mac_done = 1'b1;
        @(posedge clk); #1;
        check("hold_first_valid", vad_valid, 1);
        check("hold_state", fsm_state, 1);
        extra = 0;
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            if (vad_valid) extra++;
        end
        check("hold_extra_pulses", extra, 0);
        mac_done = 1'b0;

        frame(5, 1, 0, 2'd1);
        frame(5, 1, 1, 2'd2);

        // Flush coincident with a frame rise while in SPEECH drops that frame.
        @(posedge clk); #1;
        score_speech = 8'sd1; score_noise = 8'sd5; mac_done = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_valid", vad_valid, 0);
        check("flush_out", vad_out, 0);
        check("flush_state", fsm_state, 0);
`ifdef VAD_STATS_EN
        check("flush_frames", speech_frames, 0);
`endif
        @(posedge clk); #1;
        check("flush_no_reaccept", vad_valid, 0);
        mac_done = 1'b0;

        // Reset mid-onset discards the partial count.
        frame(5, 1, 0, 2'd1);
        frame(5, 1, 0, 2'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        frame(5, 1, 0, 2'd1);
        frame(5, 1, 0, 2'd1);
        frame(5, 1, 1, 2'd2);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
